trap_ctrl: RTL and testbench

Parametrised machine-mode trap controller for the RISC-V core. Detects synchronous exceptions and enabled external interrupts against the committing instruction and owns the trap CSRs: mstatus.MIE/MPIE, mie, mip, mtvec, mepc, mcause and mtval (mbadaddr). It prioritises competing causes, updates the CSRs and issues a one-cycle PC redirect, either to the handler or back from `mret`. It sits beside the CSR file at the commit stage; the core performs the fetch redirect and the flush.

---
 rtl/trap_pkg.sv | 37 +++
 rtl/trap_prio.sv | 68 ++++++
 rtl/trap_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_trap_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_pkg.sv
// -----------------------------------------------------------------------------
// trap_pkg: shared constants and types for the machine-mode trap controller.
//   - CSR addresses of the trap CSRs
//   - exception / interrupt cause codes (low bits of mcause)
//   - mstatus bit positions
//   - trap controller FSM state encoding
// Optional feature macro used by the users of this package:
//   TRAP_CTRL_VECTORED_EN enables vectored interrupt dispatch via mtvec[1:0].
// -----------------------------------------------------------------------------
package trap_pkg;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MIE     = 12'h304;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MTVAL   = 12'h343;
   localparam logic [11:0] CSR_MIP     = 12'h344;

   localparam logic [4:0] CAUSE_FETCH_MISALIGN = 5'd0;
   localparam logic [4:0] CAUSE_ILLEGAL        = 5'd2;
   localparam logic [4:0] CAUSE_EBREAK         = 5'd3;
   localparam logic [4:0] CAUSE_LOAD_MISALIGN  = 5'd4;
   localparam logic [4:0] CAUSE_STORE_MISALIGN = 5'd6;
   localparam logic [4:0] CAUSE_ECALL          = 5'd11;
   localparam logic [4:0] CAUSE_IRQ_BASE       = 5'd16;

   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      TAKE = 2'd1,
      RET  = 2'd2
   } state_e;

endpackage

// File: rtl/trap_prio.sv
// -----------------------------------------------------------------------------
// trap_prio: combinational priority encoder for the trap controller.
// Ports:
//   valid_i          instruction commits this cycle (gates everything)
//   pc_lo_i          pc[1:0] of the committing instruction
//   exc_illegal_i, exc_ecall_i, exc_ebreak_i   decode exceptions
//   ld_misalign_i, st_misalign_i               memory misalignment flags
//   ip_i             pending-and-enabled interrupt lines
//   trap_o           a trap is to be taken
//   is_irq_o         the winning cause is an interrupt
//   code_o           cause code (low bits of mcause)
// Order: interrupt (lowest line wins), fetch misaligned, illegal, ebreak,
// ecall, load misaligned, store misaligned.
// -----------------------------------------------------------------------------
module trap_prio
   import trap_pkg::*;
#(
   parameter int NUM_IRQ = 4
) (
   input  logic               valid_i,
   input  logic [1:0]         pc_lo_i,
   input  logic               exc_illegal_i,
   input  logic               exc_ecall_i,
   input  logic               exc_ebreak_i,
   input  logic               ld_misalign_i,
   input  logic               st_misalign_i,
   input  logic [NUM_IRQ-1:0] ip_i,
   output logic               trap_o,
   output logic               is_irq_o,
   output logic [4:0]         code_o
);

   always_comb begin
      trap_o   = 1'b0;
      is_irq_o = 1'b0;
      code_o   = '0;
      if (valid_i) begin
         if (|ip_i) begin
            trap_o   = 1'b1;
            is_irq_o = 1'b1;
            code_o   = CAUSE_IRQ_BASE;
            // Scan downwards so the lowest set line is the last to assign.
            for (int i = NUM_IRQ - 1; i >= 0; i--) begin
               if (ip_i[i]) code_o = CAUSE_IRQ_BASE + 5'(i);
            end
         end else if (pc_lo_i != 2'b00) begin
            trap_o = 1'b1;
            code_o = CAUSE_FETCH_MISALIGN;
         end else if (exc_illegal_i) begin
            trap_o = 1'b1;
            code_o = CAUSE_ILLEGAL;
         end else if (exc_ebreak_i) begin
            trap_o = 1'b1;
            code_o = CAUSE_EBREAK;
         end else if (exc_ecall_i) begin
            trap_o = 1'b1;
            code_o = CAUSE_ECALL;
         end else if (ld_misalign_i) begin
            trap_o = 1'b1;
            code_o = CAUSE_LOAD_MISALIGN;
         end else if (st_misalign_i) begin
            trap_o = 1'b1;
            code_o = CAUSE_STORE_MISALIGN;
         end
      end
   end

endmodule

// File: rtl/trap_ctrl.sv
// -----------------------------------------------------------------------------
// trap_ctrl: machine-mode trap controller. Detects exceptions and enabled
// interrupts on the committing instruction, owns mstatus.MIE/MPIE, mie, mip,
// mtvec, mepc, mcause, mtval and issues a one-cycle fetch redirect for trap
// entry and mret.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   instr_valid, pc     committing instruction and its PC
//   exc_*, ld/st_misalign, mem_addr   exception sources and faulting address
//   mret                committing instruction is mret
//   irq                 level-sensitive interrupt lines (mip[16+:NUM_IRQ])
//   csr_we/addr/wdata   CSR write port; csr_rdata combinational read
//   redirect, redirect_pc   one-cycle redirect pulse and target
//   busy                high in TAKE/RET; core holds instr_valid low
// Macro: TRAP_CTRL_VECTORED_EN makes mtvec[1:0] writable; mode 1 sends
// interrupts to base + 4*cause.
// Handshake: a trap or mret detected in IDLE (cycle N) is registered; the
// FSM spends exactly cycle N+1 in TAKE/RET with redirect and busy high, and
// the CSR side effects land at the end of that cycle.
// -----------------------------------------------------------------------------
module trap_ctrl
   import trap_pkg::*;
#(
   parameter int              XLEN      = 32,
   parameter int              NUM_IRQ   = 4,
   parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0100
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               instr_valid,
   input  logic [XLEN-1:0]    pc,
   input  logic               exc_illegal,
   input  logic               exc_ecall,
   input  logic               exc_ebreak,
   input  logic               ld_misalign,
   input  logic               st_misalign,
   input  logic [XLEN-1:0]    mem_addr,
   input  logic               mret,
   input  logic [NUM_IRQ-1:0] irq,
   input  logic               csr_we,
   input  logic [11:0]        csr_addr,
   input  logic [XLEN-1:0]    csr_wdata,
   output logic [XLEN-1:0]    csr_rdata,
   output logic               redirect,
   output logic [XLEN-1:0]    redirect_pc,
   output logic               busy
);

   state_e              state_q, state_d;
   logic                mstatus_mie_q, mstatus_mie_d;
   logic                mstatus_mpie_q, mstatus_mpie_d;
   logic [NUM_IRQ-1:0]  mie_q, mie_d;
   logic [XLEN-1:0]     mtvec_q, mtvec_d;
   logic [XLEN-1:0]     mepc_q, mepc_d;
   logic [XLEN-1:0]     mcause_q, mcause_d;
   logic [XLEN-1:0]     mtval_q, mtval_d;
   // Trap details captured in the detection cycle, committed in TAKE.
   logic [XLEN-1:0]     cause_q, cause_d;
   logic [XLEN-1:0]     epc_q, epc_d;
   logic [XLEN-1:0]     tval_q, tval_d;

   logic [NUM_IRQ-1:0]  ip;
   logic                trap_v;
   logic                trap_irq;
   logic [4:0]          trap_code;
   logic [XLEN-1:0]     base;
   logic [XLEN-1:0]     take_target;

   assign ip = irq & mie_q & {NUM_IRQ{mstatus_mie_q}};

   trap_prio #(.NUM_IRQ(NUM_IRQ)) u_prio (
      .valid_i       (instr_valid),
      .pc_lo_i       (pc[1:0]),
      .exc_illegal_i (exc_illegal),
      .exc_ecall_i   (exc_ecall),
      .exc_ebreak_i  (exc_ebreak),
      .ld_misalign_i (ld_misalign),
      .st_misalign_i (st_misalign),
      .ip_i          (ip),
      .trap_o        (trap_v),
      .is_irq_o      (trap_irq),
      .code_o        (trap_code)
   );

   assign base = {mtvec_q[XLEN-1:2], 2'b00};

   always_comb begin
      take_target = base;
`ifdef TRAP_CTRL_VECTORED_EN
      // 4*(cause & 0x7FFF_FFFF) modulo 2^XLEN is just the low bits shifted.
      if (mtvec_q[1:0] == 2'b01 && cause_q[XLEN-1])
         take_target = base + {cause_q[XLEN-3:0], 2'b00};
`endif
   end

   always_comb begin
      state_d        = state_q;
      mstatus_mie_d  = mstatus_mie_q;
      mstatus_mpie_d = mstatus_mpie_q;
      mie_d          = mie_q;
      mtvec_d        = mtvec_q;
      mepc_d         = mepc_q;
      mcause_d       = mcause_q;
      mtval_d        = mtval_q;
      cause_d        = cause_q;
      epc_d          = epc_q;
      tval_d         = tval_q;
      case (state_q)
         IDLE: begin
            if (trap_v) begin
               state_d = TAKE;
               cause_d = {trap_irq, {(XLEN-6){1'b0}}, trap_code};
               epc_d   = {pc[XLEN-1:2], 2'b00};
               if (!trap_irq && trap_code == CAUSE_FETCH_MISALIGN)
                  tval_d = pc;
               else if (!trap_irq && (trap_code == CAUSE_LOAD_MISALIGN ||
                                      trap_code == CAUSE_STORE_MISALIGN))
                  tval_d = mem_addr;
               else
                  tval_d = '0;
            end else if (instr_valid && mret) begin
               state_d = RET;
            end else if (csr_we) begin
               case (csr_addr)
                  CSR_MSTATUS: begin
                     mstatus_mie_d  = csr_wdata[MSTATUS_MIE];
                     mstatus_mpie_d = csr_wdata[MSTATUS_MPIE];
                  end
                  CSR_MIE:    mie_d = csr_wdata[16 +: NUM_IRQ];
`ifdef TRAP_CTRL_VECTORED_EN
                  CSR_MTVEC:  mtvec_d = {csr_wdata[XLEN-1:2], 1'b0, csr_wdata[0]};
`else
                  CSR_MTVEC:  mtvec_d = {csr_wdata[XLEN-1:2], 2'b00};
`endif
                  CSR_MEPC:   mepc_d   = {csr_wdata[XLEN-1:2], 2'b00};
                  CSR_MCAUSE: mcause_d = csr_wdata;
                  CSR_MTVAL:  mtval_d  = csr_wdata;
                  default: ;
               endcase
            end
         end
         TAKE: begin
            state_d        = IDLE;
            mepc_d         = epc_q;
            mcause_d       = cause_q;
            mtval_d        = tval_q;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
         end
         RET: begin
            state_d        = IDLE;
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         mstatus_mie_q  <= 1'b0;
         mstatus_mpie_q <= 1'b0;
         mie_q          <= '0;
         mtvec_q        <= RESET_VEC;
         mepc_q         <= '0;
         mcause_q       <= '0;
         mtval_q        <= '0;
         cause_q        <= '0;
         epc_q          <= '0;
         tval_q         <= '0;
      end else begin
         state_q        <= state_d;
         mstatus_mie_q  <= mstatus_mie_d;
         mstatus_mpie_q <= mstatus_mpie_d;
         mie_q          <= mie_d;
         mtvec_q        <= mtvec_d;
         mepc_q         <= mepc_d;
         mcause_q       <= mcause_d;
         mtval_q        <= mtval_d;
         cause_q        <= cause_d;
         epc_q          <= epc_d;
         tval_q         <= tval_d;
      end
   end

   assign busy     = (state_q != IDLE);
   assign redirect = busy;

   always_comb begin
      redirect_pc = '0;
      if (state_q == TAKE)     redirect_pc = take_target;
      else if (state_q == RET) redirect_pc = mepc_q;
   end

   always_comb begin
      csr_rdata = '0;
      case (csr_addr)
         CSR_MSTATUS: begin
            csr_rdata[MSTATUS_MIE]  = mstatus_mie_q;
            csr_rdata[MSTATUS_MPIE] = mstatus_mpie_q;
         end
         CSR_MIE:    csr_rdata[16 +: NUM_IRQ] = mie_q;
         CSR_MIP:    csr_rdata[16 +: NUM_IRQ] = irq;
         CSR_MTVEC:  csr_rdata = mtvec_q;
         CSR_MEPC:   csr_rdata = mepc_q;
         CSR_MCAUSE: csr_rdata = mcause_q;
         CSR_MTVAL:  csr_rdata = mtval_q;
         default:    csr_rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_trap_ctrl.sv
// -----------------------------------------------------------------------------
// tb_trap_ctrl: directed bench for trap_ctrl (NUM_IRQ = 4, RESET_VEC = 0x100).
// Expected redirect targets are queued when a trap/mret is driven and popped
// when the redirect pulse appears.
// -----------------------------------------------------------------------------
module tb_trap_ctrl;
   import trap_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        instr_valid;
   logic [31:0] pc;
   logic        exc_illegal, exc_ecall, exc_ebreak;
   logic        ld_misalign, st_misalign;
   logic [31:0] mem_addr;
   logic        mret;
   logic [3:0]  irq;
   logic        csr_we;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        busy;

   int n_chk  = 0;
   int n_fail = 0;
   logic [31:0] exp_q[$];

`ifdef TRAP_CTRL_VECTORED_EN
   localparam logic [31:0] EXP_MTVEC_RD = 32'h0000_1001;
   localparam logic [31:0] EXP_IRQ2_TGT = 32'h0000_1048;
`else
   localparam logic [31:0] EXP_MTVEC_RD = 32'h0000_1000;
   localparam logic [31:0] EXP_IRQ2_TGT = 32'h0000_1000;
`endif

   trap_ctrl #(.XLEN(32), .NUM_IRQ(4), .RESET_VEC(32'h0000_0100)) dut (
      .clk         (clk),
      .reset       (reset),
      .instr_valid (instr_valid),
      .pc          (pc),
      .exc_illegal (exc_illegal),
      .exc_ecall   (exc_ecall),
      .exc_ebreak  (exc_ebreak),
      .ld_misalign (ld_misalign),
      .st_misalign (st_misalign),
      .mem_addr    (mem_addr),
      .mret        (mret),
      .irq         (irq),
      .csr_we      (csr_we),
      .csr_addr    (csr_addr),
      .csr_wdata   (csr_wdata),
      .csr_rdata   (csr_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .busy        (busy)
   );

   // clock
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      instr_valid = 1'b0;
      exc_illegal = 1'b0;
      exc_ecall   = 1'b0;
      exc_ebreak  = 1'b0;
      ld_misalign = 1'b0;
      st_misalign = 1'b0;
      mret        = 1'b0;
      csr_we      = 1'b0;
      csr_wdata   = '0;
      mem_addr    = '0;
   endtask

   task automatic chk_csr(input string tag, input logic [11:0] a, input logic [31:0] exp);
      csr_addr = a;
      #1;
      chk(tag, csr_rdata, exp);
   endtask

   task automatic wr_csr(input logic [11:0] a, input logic [31:0] d);
      instr_valid = 1'b1;
      pc          = 32'h0;
      csr_we      = 1'b1;
      csr_addr    = a;
      csr_wdata   = d;
      tick();
      clear_inputs();
   endtask

   // Drive the already-staged instruction for one cycle, then wait (bounded)
   // for the redirect pulse and check target, pre-update mcause and width.
   task automatic fire(input string tag, input logic [31:0] tgt, input logic [31:0] pre_mcause);
      int cyc;
      logic [31:0] exp_tgt;
      exp_q.push_back(tgt);
      instr_valid = 1'b1;
      tick();
      clear_inputs();
      cyc = 0;
      while (redirect !== 1'b1 && cyc < 4) begin
         tick();
         cyc++;
      end
      chk({tag, "_redirect"}, {31'b0, redirect}, 32'd1);
      exp_tgt = exp_q.pop_front();
      chk({tag, "_target"}, redirect_pc, exp_tgt);
      chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
      chk_csr({tag, "_mcause_pre"}, CSR_MCAUSE, pre_mcause);
      tick();
      chk({tag, "_pulse_end"}, {31'b0, redirect}, 32'd0);
   endtask

   initial begin
      reset    = 1'b1;
      pc       = '0;
      irq      = '0;
      csr_addr = '0;
      clear_inputs();
      repeat (3) tick();
      reset = 1'b0;

      // reset state
      chk("rst_redirect", {31'b0, redirect}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_redirect_pc", redirect_pc, 32'd0);
      chk_csr("rst_mtvec", CSR_MTVEC, 32'h100);
      chk_csr("rst_mstatus", CSR_MSTATUS, 32'h0);
      chk_csr("rst_mie", CSR_MIE, 32'h0);
      chk_csr("rst_mcause", CSR_MCAUSE, 32'h0);
      tick();

      // enable irq[0] globally and take it at pc 0x200
      wr_csr(CSR_MIE, 32'h0001_0000);
      wr_csr(CSR_MSTATUS, 32'h8);
      chk_csr("mie_wr", CSR_MIE, 32'h0001_0000);
      chk_csr("mstatus_wr", CSR_MSTATUS, 32'h8);
      irq = 4'b0001;
      pc  = 32'h200;
      fire("irq0", 32'h100, 32'h0);
      chk_csr("irq0_mcause", CSR_MCAUSE, 32'h8000_0010);
      chk_csr("irq0_mepc", CSR_MEPC, 32'h200);
      chk_csr("irq0_mstatus", CSR_MSTATUS, 32'h80);
      chk_csr("irq0_mtval", CSR_MTVAL, 32'h0);
      irq = 4'b0000;

      // mret returns to mepc and restores MIE
      pc   = 32'h204;
      mret = 1'b1;
      fire("mret", 32'h200, 32'h8000_0010);
      chk_csr("mret_mstatus", CSR_MSTATUS, 32'h88);

      // misaligned fetch
      pc = 32'h102;
      fire("fetch", 32'h100, 32'h8000_0010);
      chk_csr("fetch_mcause", CSR_MCAUSE, 32'h0);
      chk_csr("fetch_mtval", CSR_MTVAL, 32'h102);
      chk_csr("fetch_mepc", CSR_MEPC, 32'h100);
      chk_csr("fetch_mstatus", CSR_MSTATUS, 32'h80);

      // illegal beats ecall and load misaligned
      pc = 32'h300; exc_illegal = 1'b1; exc_ecall = 1'b1; ld_misalign = 1'b1;
      mem_addr = 32'h55;
      fire("triple", 32'h100, 32'h0);
      chk_csr("triple_mcause", CSR_MCAUSE, 32'd2);
      chk_csr("triple_mtval", CSR_MTVAL, 32'h0);
      chk_csr("triple_mepc", CSR_MEPC, 32'h300);

      // load misaligned alone
      pc = 32'h304; ld_misalign = 1'b1; mem_addr = 32'h1235;
      fire("ldmis", 32'h100, 32'd2);
      chk_csr("ldmis_mcause", CSR_MCAUSE, 32'd4);
      chk_csr("ldmis_mtval", CSR_MTVAL, 32'h1235);

      // store misaligned alone
      pc = 32'h308; st_misalign = 1'b1; mem_addr = 32'hABCD;
      fire("stmis", 32'h100, 32'd4);
      chk_csr("stmis_mcause", CSR_MCAUSE, 32'd6);
      chk_csr("stmis_mtval", CSR_MTVAL, 32'hABCD);

      // ebreak beats ecall
      pc = 32'h30C; exc_ebreak = 1'b1; exc_ecall = 1'b1;
      fire("ebrk", 32'h100, 32'd6);
      chk_csr("ebrk_mcause", CSR_MCAUSE, 32'd3);

      // ecall beats load misaligned; tval is 0
      pc = 32'h310; exc_ecall = 1'b1; ld_misalign = 1'b1; mem_addr = 32'h77;
      fire("ecall", 32'h100, 32'd3);
      chk_csr("ecall_mcause", CSR_MCAUSE, 32'd11);
      chk_csr("ecall_mtval", CSR_MTVAL, 32'h0);

      // CSR write alongside a trap is dropped
      pc = 32'h314; exc_ecall = 1'b1;
      csr_we = 1'b1; csr_addr = CSR_MIE; csr_wdata = 32'h000F_0000;
      fire("drop", 32'h100, 32'd11);
      chk_csr("drop_mie", CSR_MIE, 32'h0001_0000);
      chk_csr("drop_mepc", CSR_MEPC, 32'h314);

      // mtvec mode bits, irq priority, vectored dispatch
      wr_csr(CSR_MTVEC, 32'h1001);
      wr_csr(CSR_MIE, 32'h000F_0000);
      wr_csr(CSR_MSTATUS, 32'h8);
      chk_csr("mtvec_rd", CSR_MTVEC, EXP_MTVEC_RD);
      chk_csr("mie_all", CSR_MIE, 32'h000F_0000);
      irq = 4'b1100;
      chk_csr("mip_rd", CSR_MIP, 32'h000C_0000);
      pc = 32'h400;
      fire("irq2", EXP_IRQ2_TGT, 32'd11);
      chk_csr("irq2_mcause", CSR_MCAUSE, 32'h8000_0012);
      chk_csr("irq2_mepc", CSR_MEPC, 32'h400);
      irq = 4'b0000;

      // exceptions always go to the base
      pc = 32'h404; exc_ebreak = 1'b1;
      fire("exc_base", 32'h1000, 32'h8000_0012);
      chk_csr("exc_base_mcause", CSR_MCAUSE, 32'd3);

      // no interrupt without a committing instruction
      wr_csr(CSR_MSTATUS, 32'h8);
      irq = 4'b0001;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("noiv_redirect", {31'b0, redirect}, 32'd0);
         chk("noiv_busy", {31'b0, busy}, 32'd0);
      end
      irq = 4'b0000;

      // reset asserted during TAKE
      pc = 32'h500; exc_ecall = 1'b1; instr_valid = 1'b1;
      tick();
      clear_inputs();
      chk("rtake_busy_before", {31'b0, busy}, 32'd1);
      reset = 1'b1;
      tick();
      chk("rtake_redirect", {31'b0, redirect}, 32'd0);
      chk("rtake_redirect_pc", redirect_pc, 32'd0);
      chk("rtake_busy", {31'b0, busy}, 32'd0);
      chk_csr("rtake_mtvec", CSR_MTVEC, 32'h100);
      chk_csr("rtake_mstatus", CSR_MSTATUS, 32'h0);
      chk_csr("rtake_mie", CSR_MIE, 32'h0);
      chk_csr("rtake_mepc", CSR_MEPC, 32'h0);
      chk_csr("rtake_mcause", CSR_MCAUSE, 32'h0);
      chk_csr("rtake_mtval", CSR_MTVAL, 32'h0);
      reset = 1'b0;
      tick();
      chk("rtake_idle_after", {31'b0, busy}, 32'd0);

      chk("scoreboard_empty", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
